// File: rtl/snake_frame_builder_pkg.sv
// Shared constants, types and helpers for the snake frame builder.
// The grid is 8x8; a cell's flat index is y*8 + x, matching the row/bit layout of the outputs.
package snake_frame_builder_pkg;

  localparam int unsigned GRID_DIM   = 8;
  localparam int unsigned COORD_W    = 3;
  localparam int unsigned ROW_W      = GRID_DIM;
  localparam int unsigned NUM_CELLS  = GRID_DIM * GRID_DIM;
  localparam int unsigned CELL_IDX_W = 2 * COORD_W;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic [NUM_CELLS-1:0] cell_mask_t;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StFetch,
    StDrain,
    StFood,
    StCommit
  } state_e;

  // Row y occupies bits [y*8 +: 8], so the flat index is just {y, x}.
  function automatic logic [CELL_IDX_W-1:0] cell_index(coord_t x, coord_t y);
    return {y, x};
  endfunction

endpackage

// File: rtl/snake_frame_builder_if.sv
// Bus between game logic / segment RAM (master) and the frame builder (slave).
interface snake_frame_builder_if #(
  parameter int unsigned ADDR_W = 6
);
  import snake_frame_builder_pkg::*;

  logic              frame_req;
  logic [ADDR_W:0]   seg_len;
  logic [ADDR_W-1:0] seg_addr;
  coord_t            seg_x;
  coord_t            seg_y;
  coord_t            food_x;
  coord_t            food_y;
  logic              food_valid;
  logic              busy;
  logic              frame_done;
  logic [ROW_W-1:0]  row1;
  logic [ROW_W-1:0]  row2;
  logic [ROW_W-1:0]  row3;
  logic [ROW_W-1:0]  row4;
  logic [ROW_W-1:0]  row5;
  logic [ROW_W-1:0]  row6;
  logic [ROW_W-1:0]  row7;
  logic [ROW_W-1:0]  row8;

  modport master (
    output frame_req, seg_len, seg_x, seg_y, food_x, food_y, food_valid,
    input  seg_addr, busy, frame_done, row1, row2, row3, row4, row5, row6, row7, row8
  );

  modport slave (
    input  frame_req, seg_len, seg_x, seg_y, food_x, food_y, food_valid,
    output seg_addr, busy, frame_done, row1, row2, row3, row4, row5, row6, row7, row8
  );

endinterface

// File: rtl/snake_frame_builder_cell_decoder.sv
// Combinational (x, y) -> one-hot 64-cell mask, used for both body and food plotting.
module snake_frame_builder_cell_decoder
  import snake_frame_builder_pkg::*;
(
  input  coord_t     x_i,
  input  coord_t     y_i,
  output cell_mask_t mask_o
);

  always_comb begin
    mask_o = '0;
    mask_o[cell_index(x_i, y_i)] = 1'b1;
  end

endmodule

// File: rtl/snake_frame_builder.sv
// Renders snake body segments and food into eight committed row bitmaps.
// Rows are built in a shadow buffer and copied to the outputs in a single COMMIT edge.
module snake_frame_builder
  import snake_frame_builder_pkg::*;
#(
  parameter int unsigned MAX_LEN      = 64,
  parameter int unsigned ADDR_W       = 6,
  parameter int unsigned BLINK_FRAMES = 4
) (
  input  logic                  clk_in,
  input  logic                  reset,
  snake_frame_builder_if.slave  fb_io
);

  localparam int unsigned LenW   = ADDR_W + 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES + 1) : 1;
  localparam logic [LenW-1:0]   MaxLenL  = LenW'(MAX_LEN);
  localparam logic [BlinkW-1:0] BlinkTop = BlinkW'(BLINK_FRAMES - 1);

  state_e              state_q, state_d;
  logic [LenW-1:0]     len_q, len_d;
  coord_t              food_x_q, food_x_d;
  coord_t              food_y_q, food_y_d;
  logic                food_valid_q, food_valid_d;
  logic [ADDR_W-1:0]   seg_addr_q, seg_addr_d;
  logic                pipe_vld_q, pipe_vld_d;
  cell_mask_t          shadow_q, shadow_d;
  cell_mask_t          rows_q, rows_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                phase_q, phase_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;

  coord_t     dec_x, dec_y;
  cell_mask_t cell_mask;

  // One decoder serves both paths: food coordinates are only needed in StFood.
  assign dec_x = (state_q == StFood) ? food_x_q : fb_io.seg_x;
  assign dec_y = (state_q == StFood) ? food_y_q : fb_io.seg_y;

  snake_frame_builder_cell_decoder u_cell_decoder (
    .x_i    (dec_x),
    .y_i    (dec_y),
    .mask_o (cell_mask)
  );

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    seg_addr_d   = seg_addr_q;
    pipe_vld_d   = pipe_vld_q;
    shadow_d     = shadow_q;
    rows_d       = rows_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    phase_d      = phase_q;
    blink_cnt_d  = blink_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (fb_io.frame_req) begin
          len_d        = (fb_io.seg_len > MaxLenL) ? MaxLenL : fb_io.seg_len;
          food_x_d     = fb_io.food_x;
          food_y_d     = fb_io.food_y;
          food_valid_d = fb_io.food_valid;
          busy_d       = 1'b1;
          state_d      = StClear;
        end
      end
      StClear: begin
        shadow_d   = '0;
        seg_addr_d = '0;
        pipe_vld_d = 1'b0;
        state_d    = (len_q != '0) ? StFetch : StFood;
      end
      StFetch: begin
        // Data on seg_x/seg_y belongs to the address presented one cycle earlier.
        if (pipe_vld_q) begin
          shadow_d = shadow_q | cell_mask;
        end
        pipe_vld_d = 1'b1;
        if (LenW'(seg_addr_q) == len_q - LenW'(1)) begin
          state_d = StDrain;
        end else begin
          seg_addr_d = seg_addr_q + ADDR_W'(1);
        end
      end
      StDrain: begin
        shadow_d   = shadow_q | cell_mask;
        pipe_vld_d = 1'b0;
        state_d    = StFood;
      end
      StFood: begin
        if (food_valid_q && phase_q) begin
          shadow_d = shadow_q | cell_mask;
        end
        state_d = StCommit;
      end
      StCommit: begin
        rows_d  = shadow_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
        if (BLINK_FRAMES != 0) begin
          if (blink_cnt_q == BlinkTop) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      state_q      <= StIdle;
      len_q        <= '0;
      food_x_q     <= '0;
      food_y_q     <= '0;
      food_valid_q <= 1'b0;
      seg_addr_q   <= '0;
      pipe_vld_q   <= 1'b0;
      shadow_q     <= '0;
      rows_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      phase_q      <= 1'b1;
      blink_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      seg_addr_q   <= seg_addr_d;
      pipe_vld_q   <= pipe_vld_d;
      shadow_q     <= shadow_d;
      rows_q       <= rows_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      phase_q      <= phase_d;
      blink_cnt_q  <= blink_cnt_d;
    end
  end

  assign fb_io.seg_addr   = seg_addr_q;
  assign fb_io.busy       = busy_q;
  assign fb_io.frame_done = done_q;
  assign fb_io.row1       = rows_q[0*ROW_W +: ROW_W];
  assign fb_io.row2       = rows_q[1*ROW_W +: ROW_W];
  assign fb_io.row3       = rows_q[2*ROW_W +: ROW_W];
  assign fb_io.row4       = rows_q[3*ROW_W +: ROW_W];
  assign fb_io.row5       = rows_q[4*ROW_W +: ROW_W];
  assign fb_io.row6       = rows_q[5*ROW_W +: ROW_W];
  assign fb_io.row7       = rows_q[6*ROW_W +: ROW_W];
  assign fb_io.row8       = rows_q[7*ROW_W +: ROW_W];

endmodule

// File: tb/tb_snake_frame_builder.sv
// Scoreboard bench: stimulus pushes the expected frame, a negedge monitor pops on frame_done.
module tb_snake_frame_builder;
  import snake_frame_builder_pkg::*;

  localparam int unsigned MAX_LEN      = 64;
  localparam int unsigned ADDR_W       = 6;
  localparam int unsigned BLINK_FRAMES = 4;

  typedef struct {
    logic [63:0] rows;
    int          accept_cyc;
    int          lat;
    int          last_addr;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snake_frame_builder_if #(.ADDR_W(ADDR_W)) fb ();

  snake_frame_builder #(
    .MAX_LEN      (MAX_LEN),
    .ADDR_W       (ADDR_W),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clk_in (clk),
    .reset  (rst_n),
    .fb_io  (fb)
  );

  coord_t ram_x [64];
  coord_t ram_y [64];
  exp_t   sb [$];
  int     n_cmp   = 0;
  int     n_bad   = 0;
  int     cyc     = 0;
  int     frame_k = 0;

  // Synchronous segment RAM: data appears one cycle after the address.
  always @(posedge clk) begin
    fb.seg_x <= ram_x[fb.seg_addr];
    fb.seg_y <= ram_y[fb.seg_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rows_now();
    return {fb.row8, fb.row7, fb.row6, fb.row5, fb.row4, fb.row3, fb.row2, fb.row1};
  endfunction

  // Reference model: OR of the first min(len, MAX_LEN) segments plus blinking food.
  function automatic exp_t model(input int len, input coord_t fx, input coord_t fy,
                                 input logic fv, input int k, input int acc);
    exp_t e;
    int   l;
    bit   vis;
    l = (len > int'(MAX_LEN)) ? int'(MAX_LEN) : len;
    e.rows = '0;
    for (int i = 0; i < l; i++) e.rows[int'(ram_y[i]) * 8 + int'(ram_x[i])] = 1'b1;
    vis = (BLINK_FRAMES == 0) || (((k / int'(BLINK_FRAMES)) % 2) == 0);
    if (fv && vis) e.rows[int'(fy) * 8 + int'(fx)] = 1'b1;
    e.accept_cyc = acc;
    e.lat        = (l == 0) ? 3 : l + 4;
    e.last_addr  = (l == 0) ? 0 : l - 1;
    return e;
  endfunction

  // Monitor
  initial begin
    logic prev_done;
    exp_t e;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && fb.frame_done === 1'b1) begin
        check("done_width", 64'(prev_done), 64'd0);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_frame_done: got pulse expected none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          check("rows", rows_now(), e.rows);
          check("latency", 64'(cyc - e.accept_cyc), 64'(e.lat));
          check("last_seg_addr", 64'(fb.seg_addr), 64'(e.last_addr));
        end
      end
      prev_done = fb.frame_done;
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || fb.busy !== 1'b0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("wait_idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic issue(input int len, input coord_t fx, input coord_t fy, input logic fv,
                       input bit hold, input bit disturb);
    int t = 0;
    @(negedge clk);
    while (fb.busy !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      check("accept_timeout", 64'd1, 64'd0);
      return;
    end
    fb.seg_len    = 7'(len);
    fb.food_x     = fx;
    fb.food_y     = fy;
    fb.food_valid = fv;
    fb.frame_req  = 1'b1;
    sb.push_back(model(len, fx, fy, fv, frame_k, cyc + 1));
    frame_k++;
    @(posedge clk);
    #1;
    if (!hold) fb.frame_req = 1'b0;
    if (disturb) begin
      // Request and changed inputs while busy must not affect this frame.
      @(negedge clk);
      fb.frame_req  = 1'b1;
      fb.seg_len    = 7'($urandom);
      fb.food_x     = 3'($urandom);
      fb.food_y     = 3'($urandom);
      fb.food_valid = 1'($urandom);
      @(negedge clk);
      fb.frame_req  = hold;
    end
  endtask

  task automatic fill_ram_random();
    for (int i = 0; i < 64; i++) begin
      ram_x[i] = 3'($urandom);
      ram_y[i] = 3'($urandom);
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    frame_k = 0;
    repeat (cycles) @(negedge clk);
    check("reset_rows", rows_now(), 64'd0);
    check("reset_busy", 64'(fb.busy), 64'd0);
    check("reset_done", 64'(fb.frame_done), 64'd0);
    check("reset_seg_addr", 64'(fb.seg_addr), 64'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    fb.frame_req  = 1'b0;
    fb.seg_len    = '0;
    fb.food_x     = '0;
    fb.food_y     = '0;
    fb.food_valid = 1'b0;
    fill_ram_random();
    do_reset(3);

    // Three segments on row 0, no food.
    ram_x[0] = 3'd0; ram_y[0] = 3'd0;
    ram_x[1] = 3'd1; ram_y[1] = 3'd0;
    ram_x[2] = 3'd2; ram_y[2] = 3'd0;
    issue(3, 3'd5, 3'd5, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("len3_row1", 64'(fb.row1), 64'h07);

    // Empty body, food in the far corner.
    issue(0, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0);
    wait_idle();
    check("len0_row8", 64'(fb.row8), 64'h80);

    // Duplicate segments with food on top of them.
    ram_x[0] = 3'd3; ram_y[0] = 3'd4;
    ram_x[1] = 3'd3; ram_y[1] = 3'd4;
    issue(2, 3'd3, 3'd4, 1'b1, 1'b0, 1'b0);
    wait_idle();
    check("overlap_rows", rows_now(), 64'h08 << 32);

    // Oversized length is clamped; disturbances while busy are ignored.
    fill_ram_random();
    issue(100, 3'($urandom), 3'($urandom), 1'b1, 1'b0, 1'b1);
    wait_idle();

    // Reset in the middle of the fetch phase aborts the frame.
    issue(40, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    do_reset(2);
    repeat (60) @(negedge clk);
    issue(5, 3'd2, 3'd6, 1'b1, 1'b0, 1'b0);
    wait_idle();

    // Back-to-back frames with frame_req held high; food blinks every four commits.
    do_reset(1);
    fill_ram_random();
    for (int f = 0; f < 8; f++) issue(int'($urandom_range(0, 6)), 3'd0, 3'd0, 1'b1, f != 7, 1'b0);
    wait_idle();

    // Randomized frames.
    for (int n = 0; n < 12; n++) begin
      wait_idle();
      fill_ram_random();
      issue(int'($urandom_range(0, 70)), 3'($urandom), 3'($urandom), 1'($urandom),
            1'b0, 1'($urandom));
    end
    wait_idle();
    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

endmodule
